// File: rtl/rf_pkg.sv
// Shared defaults and FSM encoding for the scoreboarded register file.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// One busy bit per register entry: issue sets, writeback or bulk clear resets.
module reg_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              busy1,
    output logic              busy2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Set is applied last so a new producer wins over a same-cycle writeback.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1 = busy_q[rd_addr1];
    assign busy2 = busy_q[rd_addr2];

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write forwarding, a busy scoreboard
// and a sequential bulk clear that sweeps one entry per cycle.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              clr_start,
    output logic              clr_active,
    output logic              clr_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              clr_done_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic idle;
    logic wr_ok;
    logic set_ok;
    logic sb_clr_en;
    logic [ADDR_W-1:0] sb_clr_addr;

    assign idle   = (state_q == IDLE);
    assign wr_ok  = idle && wr_en && !(ZERO_REG && (wr_addr == '0));
    assign set_ok = idle && iss_en && !(ZERO_REG && (iss_addr == '0));

    // During CLEAR the scoreboard clear port is owned by the sweep index.
    assign sb_clr_en   = idle ? wr_en : 1'b1;
    assign sb_clr_addr = idle ? wr_addr : idx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    clr_done_q <= 1'b0;
                    if (clr_start) begin
                        state_q <= CLEAR;
                        idx_q   <= '0;
                    end
                end
                CLEAR: begin
                    if (idx_q == LAST_IDX) begin
                        state_q    <= IDLE;
                        clr_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            mem_q[idx_q] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    logic [1:0][ADDR_W-1:0] rd_addr_w;
    logic [1:0][DATA_W-1:0] rd_data_w;
    logic [1:0]             sb_busy;
    logic [1:0]             rd_busy_w;

    assign rd_addr_w = {rd_addr2, rd_addr1};

    reg_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_ok),
        .set_addr (iss_addr),
        .clr_en   (sb_clr_en),
        .clr_addr (sb_clr_addr),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .busy1    (sb_busy[0]),
        .busy2    (sb_busy[1])
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic fwd;
            logic zero;
            assign fwd  = idle && wr_en && (wr_addr == rd_addr_w[gi]);
            assign zero = ZERO_REG && (rd_addr_w[gi] == '0);
            assign rd_data_w[gi] = zero ? '0 : (fwd ? wr_data : mem_q[rd_addr_w[gi]]);
            assign rd_busy_w[gi] = !zero && sb_busy[gi] && !fwd;
        end
    endgenerate

    assign rd_data1   = rd_data_w[0];
    assign rd_data2   = rd_data_w[1];
    assign rd_busy1   = rd_busy_w[0];
    assign rd_busy2   = rd_busy_w[1];
    assign clr_active = (state_q == CLEAR);
    assign clr_done   = clr_done_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: single-cycle vector table plus clear / reset / small-config sequences.
module tb_reg_file_sb;

    logic clk;
    logic reset;

    // default configuration instance
    logic [4:0]  a_rd_addr1, a_rd_addr2, a_wr_addr, a_iss_addr;
    logic [31:0] a_rd_data1, a_rd_data2, a_wr_data;
    logic        a_rd_busy1, a_rd_busy2, a_wr_en, a_iss_en, a_clr_start, a_clr_active, a_clr_done;

    // DATA_W=16, ADDR_W=3 instance
    logic [2:0]  b_rd_addr1, b_rd_addr2, b_wr_addr, b_iss_addr;
    logic [15:0] b_rd_data1, b_rd_data2, b_wr_data;
    logic        b_rd_busy1, b_rd_busy2, b_wr_en, b_iss_en, b_clr_start, b_clr_active, b_clr_done;

    int checks = 0;
    int failures = 0;

    reg_file_sb dut (
        .clk(clk), .reset(reset),
        .rd_addr1(a_rd_addr1), .rd_addr2(a_rd_addr2),
        .rd_data1(a_rd_data1), .rd_data2(a_rd_data2),
        .rd_busy1(a_rd_busy1), .rd_busy2(a_rd_busy2),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .iss_en(a_iss_en), .iss_addr(a_iss_addr),
        .clr_start(a_clr_start), .clr_active(a_clr_active), .clr_done(a_clr_done)
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) dut8 (
        .clk(clk), .reset(reset),
        .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2),
        .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
        .rd_busy1(b_rd_busy1), .rd_busy2(b_rd_busy2),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_en(b_iss_en), .iss_addr(b_iss_addr),
        .clr_start(b_clr_start), .clr_active(b_clr_active), .clr_done(b_clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          ie;
        logic [4:0]  ia;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        bit          b1;
        bit          b2;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(bit we, logic [4:0] wa, logic [31:0] wd, bit ie, logic [4:0] ia,
                                logic [4:0] r1, logic [4:0] r2, logic [31:0] e1, logic [31:0] e2,
                                bit b1, bit b2);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
        v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    int cnt;
    int dones;
    bit exited;
    int bad;

    initial begin
        vecs[0]  = mk(0, 0, 32'h0,        0, 0,  3,  7, 32'h0,        32'h0,        0, 0);
        vecs[1]  = mk(1, 3, 32'hDEADBEEF, 0, 0,  0,  0, 32'h0,        32'h0,        0, 0);
        vecs[2]  = mk(0, 0, 32'h0,        0, 0,  3,  3, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        vecs[3]  = mk(1, 7, 32'h12345678, 0, 0,  7,  7, 32'h12345678, 32'h12345678, 0, 0);
        vecs[4]  = mk(1, 0, 32'hFFFFFFFF, 0, 0,  0,  0, 32'h0,        32'h0,        0, 0);
        vecs[5]  = mk(0, 0, 32'h0,        0, 0,  0,  7, 32'h0,        32'h12345678, 0, 0);
        vecs[6]  = mk(0, 0, 32'h0,        1, 5,  5,  5, 32'h0,        32'h0,        0, 0);
        vecs[7]  = mk(0, 0, 32'h0,        0, 0,  5,  0, 32'h0,        32'h0,        1, 0);
        vecs[8]  = mk(1, 5, 32'hAAAA5555, 1, 5,  5,  5, 32'hAAAA5555, 32'hAAAA5555, 0, 0);
        vecs[9]  = mk(0, 0, 32'h0,        0, 0,  5,  5, 32'hAAAA5555, 32'hAAAA5555, 1, 1);
        vecs[10] = mk(1, 5, 32'h00000055, 0, 0,  5,  3, 32'h00000055, 32'hDEADBEEF, 0, 0);
        vecs[11] = mk(0, 0, 32'h0,        0, 0,  5,  5, 32'h00000055, 32'h00000055, 0, 0);
        vecs[12] = mk(0, 0, 32'h0,        1, 0,  0,  0, 32'h0,        32'h0,        0, 0);
        vecs[13] = mk(0, 0, 32'h0,        0, 0,  0,  3, 32'h0,        32'hDEADBEEF, 0, 0);
        vecs[14] = mk(0, 0, 32'h0,        1, 12, 12, 3, 32'h0,        32'hDEADBEEF, 0, 0);
        vecs[15] = mk(0, 0, 32'h0,        0, 0,  12, 12, 32'h0,       32'h0,        1, 1);

        a_rd_addr1 = 0; a_rd_addr2 = 0; a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0;
        a_iss_en = 0; a_iss_addr = 0; a_clr_start = 0;
        b_rd_addr1 = 0; b_rd_addr2 = 0; b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0;
        b_iss_en = 0; b_iss_addr = 0; b_clr_start = 0;

        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_a_data1", a_rd_data1, 32'h0);
        chk("rst_a_busy1", {31'b0, a_rd_busy1}, 32'h0);
        chk("rst_a_active", {31'b0, a_clr_active}, 32'h0);
        chk("rst_a_done", {31'b0, a_clr_done}, 32'h0);
        chk("rst_b_data1", {16'b0, b_rd_data1}, 32'h0);
        chk("rst_b_active", {31'b0, b_clr_active}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // single-cycle vectors: inputs at negedge, outputs sampled before the next posedge
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_wr_en = vecs[i].we; a_wr_addr = vecs[i].wa; a_wr_data = vecs[i].wd;
            a_iss_en = vecs[i].ie; a_iss_addr = vecs[i].ia;
            a_rd_addr1 = vecs[i].r1; a_rd_addr2 = vecs[i].r2;
            #1;
            $display("vec %0d: we=%0d wa=%0d wd=%h ie=%0d ia=%0d r1=%0d->%h/%0d r2=%0d->%h/%0d",
                     i, a_wr_en, a_wr_addr, a_wr_data, a_iss_en, a_iss_addr,
                     a_rd_addr1, a_rd_data1, a_rd_busy1, a_rd_addr2, a_rd_data2, a_rd_busy2);
            chk($sformatf("v%0d_data1", i), a_rd_data1, vecs[i].e1);
            chk($sformatf("v%0d_data2", i), a_rd_data2, vecs[i].e2);
            chk($sformatf("v%0d_busy1", i), {31'b0, a_rd_busy1}, {31'b0, vecs[i].b1});
            chk($sformatf("v%0d_busy2", i), {31'b0, a_rd_busy2}, {31'b0, vecs[i].b2});
        end

        // bulk clear; the write/issue in the start cycle must still land
        @(negedge clk);
        a_clr_start = 1; a_wr_en = 1; a_wr_addr = 20; a_wr_data = 32'h00002020;
        a_iss_en = 1; a_iss_addr = 21;
        #1 chk("clr_start_active", {31'b0, a_clr_active}, 32'h0);
        @(negedge clk);
        a_clr_start = 0; a_wr_addr = 4; a_wr_data = 32'h00004444; a_iss_addr = 4;
        a_rd_addr1 = 20; a_rd_addr2 = 21;
        #1;
        $display("clear cycle 0: active=%0d r20=%h busy21=%0d", a_clr_active, a_rd_data1, a_rd_busy2);
        chk("clr_c0_active", {31'b0, a_clr_active}, 32'h1);
        chk("clr_same_cycle_wr", a_rd_data1, 32'h00002020);
        chk("clr_same_cycle_iss", {31'b0, a_rd_busy2}, 32'h1);
        a_rd_addr2 = 4;
        #1;
        chk("clr_no_fwd_data", a_rd_data2, 32'h0);
        chk("clr_no_fwd_busy", {31'b0, a_rd_busy2}, 32'h0);
        cnt = a_clr_active ? 1 : 0;
        dones = 0;
        exited = 0;
        for (int k = 0; k < 100 && !exited; k++) begin
            @(negedge clk);
            #1;
            if (a_clr_active) begin
                cnt++;
                if (a_clr_done) dones++;
            end else begin
                a_wr_en = 0; a_iss_en = 0;
                exited = 1;
                chk("clr_done_pulse", {31'b0, a_clr_done}, 32'h1);
            end
        end
        $display("clear: active cycles=%0d done during active=%0d", cnt, dones);
        chk("clr_active_cycles", cnt, 32);
        chk("clr_done_early", dones, 0);
        @(negedge clk);
        #1 chk("clr_done_once", {31'b0, a_clr_done}, 32'h0);
        bad = 0;
        for (int i = 0; i < 32; i += 2) begin
            @(negedge clk);
            a_rd_addr1 = 5'(i); a_rd_addr2 = 5'(i + 1);
            #1;
            $display("post-clear read %0d/%0d: %h/%0d %h/%0d", i, i + 1,
                     a_rd_data1, a_rd_busy1, a_rd_data2, a_rd_busy2);
            chk($sformatf("clr_rd%0d", i), {a_rd_data1[30:0], a_rd_busy1}, 32'h0);
            chk($sformatf("clr_rd%0d", i + 1), {a_rd_data2[30:0], a_rd_busy2}, 32'h0);
            if (a_rd_data1[31] || a_rd_data2[31]) bad++;
        end
        chk("clr_rd_msb", bad, 0);

        // reset in the middle of a clear
        @(negedge clk);
        a_wr_en = 1; a_wr_addr = 31; a_wr_data = 32'h00000031; a_iss_en = 1; a_iss_addr = 30;
        @(negedge clk);
        a_wr_en = 0; a_iss_en = 0; a_clr_start = 1;
        @(negedge clk);
        a_clr_start = 0; a_rd_addr1 = 31; a_rd_addr2 = 30;
        for (int k = 0; k < 10; k++) @(negedge clk);
        #1;
        $display("clear cycle 10: active=%0d r31=%h busy30=%0d", a_clr_active, a_rd_data1, a_rd_busy2);
        chk("mid_active", {31'b0, a_clr_active}, 32'h1);
        chk("mid_data31", a_rd_data1, 32'h00000031);
        chk("mid_busy30", {31'b0, a_rd_busy2}, 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("mrst_data1", a_rd_data1, 32'h0);
        chk("mrst_busy2", {31'b0, a_rd_busy2}, 32'h0);
        chk("mrst_active", {31'b0, a_clr_active}, 32'h0);
        chk("mrst_done", {31'b0, a_clr_done}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (a_clr_done) dones++;
            if (a_clr_active) cnt++;
        end
        chk("mrst_no_done", dones, 0);
        chk("mrst_no_active", cnt, 0);

        // small configuration: 8 entries of 16 bits
        @(negedge clk);
        b_wr_en = 1; b_wr_addr = 7; b_wr_data = 16'hBEEF;
        @(negedge clk);
        b_wr_en = 0; b_rd_addr1 = 7;
        #1;
        $display("dut8 read 7: %h", b_rd_data1);
        chk("p8_rd7", {16'b0, b_rd_data1}, 32'h0000BEEF);
        b_clr_start = 1;
        @(negedge clk);
        b_clr_start = 0;
        cnt = 0;
        exited = 0;
        for (int k = 0; k < 100 && !exited; k++) begin
            #1;
            if (b_clr_active) begin
                cnt++;
                @(negedge clk);
            end else begin
                exited = 1;
                chk("p8_done", {31'b0, b_clr_done}, 32'h1);
            end
        end
        $display("dut8 clear: active cycles=%0d", cnt);
        chk("p8_active_cycles", cnt, 8);
        @(negedge clk);
        #1 chk("p8_rd7_cleared", {16'b0, b_rd_data1}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
